// File: rtl/led_pkg.sv
// Shared constants and types for the LED frame builder.
// Frame geometry, FSM encoding and CPU-visible register offsets.
package led_pkg;

    localparam int NUM_LEDS   = 64;
    localparam int COLOR_BITS = 24;
    localparam int FRAME_BITS = NUM_LEDS * COLOR_BITS;
    localparam int IDX_BITS   = $clog2(NUM_LEDS);
    localparam int SHIFT_BITS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    // CPU register map: colour words occupy one 32-bit slot per LED
    localparam logic [11:0] MMIO_COLOR_BASE = 12'h000;
    localparam logic [11:0] MMIO_COMMIT     = 12'h100;
    localparam logic [11:0] MMIO_BRIGHTNESS = 12'h104;

endpackage

// File: rtl/led_color_scale.sv
// Combinational brightness scaling and RGB-to-GRB reorder for one LED.
// Zero latency; no flow control.
module led_color_scale
    import led_pkg::*;
(
    input  logic [COLOR_BITS-1:0] rgb,
    input  logic [SHIFT_BITS-1:0] shift,
    output logic [COLOR_BITS-1:0] grb
);

    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    assign red   = rgb[23:16];
    assign green = rgb[15:8];
    assign blue  = rgb[7:0];

    assign grb = {green >> shift, red >> shift, blue >> shift};

endmodule

// File: rtl/led_frame_builder.sv
// Colour store plus copy engine that rebuilds the serializer frame on commit.
// One LED per cycle, 64 cycles per pass; commits during a pass queue one extra pass.
module led_frame_builder
    import led_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_BITS-1:0]   wr_addr,
    input  logic [COLOR_BITS-1:0] wr_data,
    input  logic                  commit,
    input  logic [SHIFT_BITS-1:0] brightness,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] bits
);

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d;
    logic                  pending_q, pending_d;
    logic                  done_d;
    logic                  last_led;
    logic [COLOR_BITS-1:0] ram [NUM_LEDS];
    logic [COLOR_BITS-1:0] scaled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) ram[i] <= '0;
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Combinational read sees the pre-edge value, so a same-cycle write is not copied
    led_color_scale u_scale (
        .rgb   (ram[idx_q]),
        .shift (shift_q),
        .grb   (scaled)
    );

    assign last_led = (idx_q == IDX_BITS'(NUM_LEDS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = COPY;
                    idx_d   = '0;
                    shift_d = brightness;
                end
            end
            COPY: begin
                if (commit) pending_d = 1'b1;
                if (last_led) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    if (pending_q || commit) begin
                        pending_d = 1'b0;
                        shift_d   = brightness;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            done      <= done_d;
        end
    end

    // LED 0 lands in the top slice because the serializer shifts out the MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits <= '0;
        end else if (state_q == COPY) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (idx_q == IDX_BITS'(i))
                    bits[FRAME_BITS-1-COLOR_BITS*i -: COLOR_BITS] <= scaled;
            end
        end
    end

    assign busy = (state_q == COPY);

endmodule

// File: tb/tb_led_frame_builder.sv
// Self-checking bench for led_frame_builder: directed table, corner sequences, random traffic.
module tb_led_frame_builder;
    import led_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_en = 1'b0;
    logic [IDX_BITS-1:0]   wr_addr = '0;
    logic [COLOR_BITS-1:0] wr_data = '0;
    logic                  commit = 1'b0;
    logic [SHIFT_BITS-1:0] brightness = '0;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] bits;

    led_frame_builder dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .brightness (brightness),
        .busy       (busy),
        .done       (done),
        .bits       (bits)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pass that starts at edge S writes LED k at edge S+1+k
    logic [23:0] m_ram  [64];
    logic [23:0] m_slot [64];
    bit          m_active, m_pend, m_done;
    int          m_start, m_cycle, m_shift;

    function automatic logic [23:0] ref_scale(logic [23:0] c, int s);
        int d;
        d = 1 << s;
        return {8'(c[15:8] / d), 8'(c[23:16] / d), 8'(c[7:0] / d)};
    endfunction

    function automatic logic [FRAME_BITS-1:0] model_frame();
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int k = 0; k < 64; k++) f = {f[FRAME_BITS-25:0], m_slot[k]};
        return f;
    endfunction

    function automatic logic [23:0] dut_slot(int k);
        logic [FRAME_BITS-1:0] t;
        t = bits >> (24 * (63 - k));
        return t[23:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ram[i]  = '0;
            m_slot[i] = '0;
        end
        m_active = 0; m_pend = 0; m_done = 0; m_shift = 0; m_start = 0;
    endtask

    task automatic model_edge(bit we, int wa, logic [23:0] wd, bit cm, int br);
        int k;
        m_cycle++;
        m_done = 0;
        if (m_active) begin
            k = m_cycle - m_start - 1;
            m_slot[k] = ref_scale(m_ram[k], m_shift);
            if (cm) m_pend = 1;
            if (k == 63) begin
                m_done = 1;
                if (m_pend) begin
                    m_start = m_cycle; m_shift = br; m_pend = 0;
                end else begin
                    m_active = 0;
                end
            end
        end else if (cm) begin
            m_active = 1; m_start = m_cycle; m_shift = br;
        end
        if (we) m_ram[wa] = wd;
    endtask

    task automatic chk(string name, logic [FRAME_BITS-1:0] act, logic [FRAME_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(bit we, int wa, logic [23:0] wd, bit cm, int br);
        wr_en = we; wr_addr = 6'(wa); wr_data = wd; commit = cm; brightness = 3'(br);
        model_edge(we, wa, wd, cm, br);
        @(posedge clk);
        #1;
        chk("busy", FRAME_BITS'(busy), FRAME_BITS'(m_active));
        chk("done", FRAME_BITS'(done), FRAME_BITS'(m_done));
        chk("bits", bits, model_frame());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 24'h0, 0, int'($urandom_range(0, 7)));
    endtask

    typedef struct {
        int          addr;
        logic [23:0] data;
        int          br;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   busy_cnt, done_cnt, done_at [$];

    initial begin
        model_reset();
        m_cycle = 0;
        #3;
        chk("reset_bits", bits, '0);
        chk("reset_busy", FRAME_BITS'(busy), '0);
        chk("reset_done", FRAME_BITS'(done), '0);
        #10 reset = 1'b0;

        vecs[0] = '{0,  24'hFF0000, 0, 24'h00FF00};
        vecs[1] = '{63, 24'h123456, 1, 24'h1A092B};
        vecs[2] = '{10, 24'h80C0FF, 7, 24'h010101};
        vecs[3] = '{31, 24'hABCDEF, 4, 24'h0C0A0E};
        vecs[4] = '{5,  24'h010203, 0, 24'h020103};
        for (int v = 0; v < 5; v++) begin
            step(1, vecs[v].addr, vecs[v].data, 0, 0);
            step(0, 0, 24'h0, 1, vecs[v].br);
            idle(64);
            chk($sformatf("vec%0d_slot", v), FRAME_BITS'(dut_slot(vecs[v].addr)),
                FRAME_BITS'(vecs[v].exp));
            idle(2);
        end

        // Commits at cycles 10 and 20 of a pass collapse into one extra pass
        busy_cnt = 0; done_cnt = 0; done_at.delete();
        for (int i = 0; i < 140; i++) begin
            step(0, 0, 24'h0, (i == 0 || i == 10 || i == 20), 0);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at.push_back(i);
            end
        end
        chk("pend_busy_cycles", FRAME_BITS'(busy_cnt), FRAME_BITS'(128));
        chk("pend_done_count", FRAME_BITS'(done_cnt), FRAME_BITS'(2));
        if (done_at.size() == 2)
            chk("pend_done_gap", FRAME_BITS'(done_at[1] - done_at[0]), FRAME_BITS'(64));

        // Write to LED 5 on the same edge that copies it
        step(1, 5, 24'h112233, 0, 0);
        step(0, 0, 24'h0, 1, 0);
        idle(66);
        step(0, 0, 24'h0, 1, 0);
        idle(5);
        step(1, 5, 24'h445566, 0, 0);
        idle(60);
        chk("collide_old", FRAME_BITS'(dut_slot(5)), FRAME_BITS'(24'h221133));
        step(0, 0, 24'h0, 1, 0);
        idle(66);
        chk("collide_new", FRAME_BITS'(dut_slot(5)), FRAME_BITS'(24'h554466));

        // Reset in the middle of a pass
        step(0, 0, 24'h0, 1, 0);
        idle(31);
        reset = 1'b1;
        #2;
        chk("midreset_bits", bits, '0);
        chk("midreset_busy", FRAME_BITS'(busy), '0);
        chk("midreset_done", FRAME_BITS'(done), '0);
        model_reset();
        #2 reset = 1'b0;
        step(0, 0, 24'h0, 1, 5);
        idle(66);
        chk("postreset_zero", bits, '0);

        // Brightness wobbling during a pass must not leak into the frame
        step(1, 0, 24'hF0F0F0, 0, 0);
        step(1, 63, 24'h808080, 0, 0);
        step(0, 0, 24'h0, 1, 3);
        idle(66);
        chk("bright_first", FRAME_BITS'(dut_slot(0)), FRAME_BITS'(24'h1E1E1E));
        chk("bright_last", FRAME_BITS'(dut_slot(63)), FRAME_BITS'(24'h101010));

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 63)), 24'($urandom),
                 ($urandom_range(0, 39) == 0), int'($urandom_range(0, 7)));
        end
        idle(140);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
